// File: rtl/zoom_pkg.sv
// Shared definitions for the replication zoom scalers: zoom codes,
// code-to-factor mapping and the controller state encoding.
package zoom_pkg;

    localparam logic [1:0] ZOOM_X1 = 2'b00;
    localparam logic [1:0] ZOOM_X2 = 2'b01;
    localparam logic [1:0] ZOOM_X4 = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_EMIT = 2'd2
    } state_t;

    // The reserved code 2'b11 behaves as x1.
    function automatic logic [2:0] zoom_factor(input logic [1:0] code);
        case (code)
            ZOOM_X2: return 3'd2;
            ZOOM_X4: return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/zoom_line_buffer.sv
// One-row pixel store: synchronous write, asynchronous read so the
// output pixel follows the read column in the same cycle.
module zoom_line_buffer #(
    parameter int WIDTH   = 160,
    parameter int PIXEL_W = 8,
    parameter int ADDR_W  = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [PIXEL_W-1:0] wr_data,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [PIXEL_W-1:0] rd_data
);

    logic [PIXEL_W-1:0] mem_q [WIDTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/replication_zoom_stream.sv
// Streaming nearest-neighbour upscaler (x1/x2/x4): buffers one source row,
// then replays it rep_x times per pixel and rep_y times per line.
module replication_zoom_stream
    import zoom_pkg::*;
#(
    parameter int WIDTH   = 160,
    parameter int HEIGHT  = 120,
    parameter int PIXEL_W = 8,
    parameter int COL_W   = $clog2(WIDTH),
    parameter int ROW_W   = $clog2(HEIGHT)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         zoom,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIXEL_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PIXEL_W-1:0] out_data,
    output logic               out_eol,
    output logic               out_eof,
    output logic               busy,
    output logic               done
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [2:0]         rep_x_q, rep_x_d;
    logic [2:0]         rep_y_q, rep_y_d;
    logic [2:0]         factor_q, factor_d;
    logic               done_q, done_d;

    logic [2:0]         fact_last;
    logic               line_last;
    logic               frame_last;
    logic [PIXEL_W-1:0] rd_data;
    logic               wr_en;

    assign fact_last  = factor_q - 3'd1;
    assign line_last  = (rep_x_q == fact_last) && (col_q == COL_LAST);
    assign frame_last = line_last && (rep_y_q == fact_last) && (row_q == ROW_LAST);
    assign wr_en      = (state_q == ST_FILL) && in_valid;

    zoom_line_buffer #(
        .WIDTH   (WIDTH),
        .PIXEL_W (PIXEL_W),
        .ADDR_W  (COL_W)
    ) u_line_buffer (
        .clock   (clock),
        .wr_en   (wr_en),
        .wr_addr (col_q),
        .wr_data (in_data),
        .rd_addr (col_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        rep_x_d  = rep_x_q;
        rep_y_d  = rep_y_q;
        factor_d = factor_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    factor_d = zoom_factor(zoom);
                    state_d  = ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    if (col_q == COL_LAST) begin
                        col_d   = '0;
                        state_d = ST_EMIT;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    // Innermost rep_x, then col, then rep_y, then row.
                    if (rep_x_q != fact_last) begin
                        rep_x_d = rep_x_q + 3'd1;
                    end else begin
                        rep_x_d = '0;
                        if (col_q != COL_LAST) begin
                            col_d = col_q + COL_W'(1);
                        end else begin
                            col_d = '0;
                            if (rep_y_q != fact_last) begin
                                rep_y_d = rep_y_q + 3'd1;
                            end else begin
                                rep_y_d = '0;
                                if (row_q != ROW_LAST) begin
                                    row_d   = row_q + ROW_W'(1);
                                    state_d = ST_FILL;
                                end else begin
                                    row_d   = '0;
                                    state_d = ST_IDLE;
                                    done_d  = 1'b1;
                                end
                            end
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            col_q    <= '0;
            row_q    <= '0;
            rep_x_q  <= '0;
            rep_y_q  <= '0;
            factor_q <= 3'd1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            rep_x_q  <= rep_x_d;
            rep_y_q  <= rep_y_d;
            factor_q <= factor_d;
            done_q   <= done_d;
        end
    end

    assign in_ready  = (state_q == ST_FILL);
    assign out_valid = (state_q == ST_EMIT);
    assign out_data  = out_valid ? rd_data : '0;
    assign out_eol   = out_valid && line_last;
    assign out_eof   = out_valid && frame_last;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_replication_zoom_stream.sv
// Scoreboard bench: each frame's expected output is generated from the zoom
// rules and queued; a negedge monitor pops and compares on every transfer.
module tb_replication_zoom_stream;

    localparam int W  = 2;
    localparam int H  = 2;
    localparam int PW = 8;
    localparam int N  = W * H;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    zoom = 2'b00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [PW-1:0] out_data;
    logic          out_eol;
    logic          out_eof;
    logic          busy;
    logic          done;

    replication_zoom_stream #(.WIDTH(W), .HEIGHT(H), .PIXEL_W(PW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .zoom      (zoom),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          eol;
        logic          eof;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   xfers = 0;
    bit   mon_en = 1'b0;
    bit   rand_ready = 1'b0;
    bit   abort = 1'b0;
    bit   done_exp = 1'b0;
    bit   stall_prev = 1'b0;
    exp_t held;

    function automatic void check(string name, longint act, longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    initial begin
        forever begin
            @(posedge clock);
            #1;
            out_ready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                if (out_valid) check("in_ready_during_emit", in_ready, 0);
                check("done_pulse", done, done_exp);
                done_exp = 1'b0;
                if (stall_prev && out_valid) begin
                    check("hold_data", out_data, held.data);
                    check("hold_eol", out_eol, held.eol);
                    check("hold_eof", out_eof, held.eof);
                end
                stall_prev = out_valid && !out_ready;
                held = '{data: out_data, eol: out_eol, eof: out_eof};
                if (out_valid && out_ready) begin
                    xfers++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_output: got data %0h with empty scoreboard", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("out_eol", out_eol, e.eol);
                        check("out_eof", out_eof, e.eof);
                        done_exp = e.eof;
                    end
                end
            end
        end
    end

    // Expected frame: every source pixel repeated F times across, every line F times down.
    task automatic build_expected(input logic [PW-1:0] img [N], input logic [1:0] code);
        int f;
        exp_t e;
        f = (code == 2'b01) ? 2 : (code == 2'b10) ? 4 : 1;
        for (int r = 0; r < H; r++)
            for (int ry = 0; ry < f; ry++)
                for (int c = 0; c < W; c++)
                    for (int rx = 0; rx < f; rx++) begin
                        e.data = img[r * W + c];
                        e.eol  = (rx == f - 1) && (c == W - 1);
                        e.eof  = e.eol && (ry == f - 1) && (r == H - 1);
                        exp_q.push_back(e);
                    end
    endtask

    task automatic pulse_start(input logic [1:0] code);
        start = 1'b1;
        zoom  = code;
        @(posedge clock);
        #1;
        start = 1'b0;
        zoom  = 2'($urandom);
    endtask

    task automatic feed(input logic [PW-1:0] img [N], input bit gaps, input bit glitch);
        int idx = 0;
        int it  = 0;
        while (idx < N && !abort && it < 5000) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = img[idx];
            if (glitch && it == 3) begin
                start = 1'b1;
                zoom  = 2'b10;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            if (in_valid && in_ready) idx++;
            @(posedge clock);
            #1;
            it++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (it >= 5000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL feed_timeout: got %0d pixels accepted expected %0d", idx, N);
        end
    endtask

    task automatic run_frame(input logic [PW-1:0] img [N], input logic [1:0] code,
                             input bit gaps, input bit rdy, input bit glitch);
        int cyc = 0;
        build_expected(img, code);
        rand_ready = rdy;
        pulse_start(code);
        feed(img, gaps, glitch);
        while (exp_q.size() != 0 && cyc < 20000) begin
            @(negedge clock);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL frame_timeout: got %0d outputs outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clock);
        #1;
        check("idle_after_frame", busy, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_eol"}, out_eol, 0);
        check({tag, "_out_eof"}, out_eof, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    logic [PW-1:0] img_a [N];
    logic [PW-1:0] img_r [N];

    initial begin
        img_a = '{8'd1, 8'd2, 8'd3, 8'd4};
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        run_frame(img_a, 2'b01, 1'b0, 1'b0, 1'b0);
        run_frame(img_a, 2'b10, 1'b0, 1'b0, 1'b0);
        run_frame(img_a, 2'b00, 1'b0, 1'b0, 1'b0);
        run_frame(img_a, 2'b11, 1'b0, 1'b0, 1'b0);
        run_frame(img_a, 2'b01, 1'b1, 1'b1, 1'b0);
        run_frame(img_a, 2'b01, 1'b0, 1'b1, 1'b1);

        // Reset in the middle of an x2 frame, then a clean frame.
        build_expected(img_a, 2'b01);
        rand_ready = 1'b0;
        xfers      = 0;
        abort      = 1'b0;
        pulse_start(2'b01);
        fork
            feed(img_a, 1'b0, 1'b0);
            begin
                int c = 0;
                while (xfers < 5 && c < 1000) begin
                    @(negedge clock);
                    c++;
                end
                check("xfers_before_reset", xfers, 5);
                @(posedge clock);
                #1;
                mon_en = 1'b0;
                reset  = 1'b1;
                abort  = 1'b1;
            end
        join
        @(posedge clock);
        @(negedge clock);
        check_reset_outputs("midframe_reset");
        exp_q.delete();
        stall_prev = 1'b0;
        done_exp   = 1'b0;
        abort      = 1'b0;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        run_frame(img_a, 2'b01, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            for (int p = 0; p < N; p++) img_r[p] = PW'($urandom);
            run_frame(img_r, 2'($urandom), bit'($urandom), bit'($urandom), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
